// File: rtl/atmega_pio_arb.sv
// Round-robin arbiter that shares one atmega_pio register port among NUM_REQ masters.
// Each grant runs exactly one PIO access (IDLE -> ACCESS -> ACK); m_lock keeps ownership for RMW.
module atmega_pio_arb #(
    parameter int NUM_REQ           = 2,
    parameter int BUS_ADDR_DATA_LEN = 8,
    parameter int PORT_WIDTH        = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   m_req,
    input  logic [NUM_REQ-1:0]                   m_lock,
    input  logic [NUM_REQ-1:0]                   m_wr,
    input  logic [NUM_REQ-1:0]                   m_rd,
    input  logic [NUM_REQ*BUS_ADDR_DATA_LEN-1:0] m_addr,
    input  logic [NUM_REQ*PORT_WIDTH-1:0]        m_wdata,
    output logic [NUM_REQ-1:0]                   m_ack,
    output logic [PORT_WIDTH-1:0]                m_rdata,
    output logic [1:0]                           grant_id,
    output logic                                 busy,
    output logic [BUS_ADDR_DATA_LEN-1:0]         pio_addr,
    output logic                                 pio_wr,
    output logic                                 pio_rd,
    output logic [PORT_WIDTH-1:0]                pio_wdata,
    input  logic [PORT_WIDTH-1:0]                pio_rdata
);
    localparam int AW = BUS_ADDR_DATA_LEN;
    localparam int DW = PORT_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    owner_q, owner_d;
    logic          lock_valid_q, lock_valid_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [DW-1:0] rdata_q;

    logic [3:0]    elig;
    logic [3:0]    lock_pad;
    logic          lock_release;
    logic          win_found;
    logic [1:0]    win_idx;

    function automatic logic [1:0] rr_next(input logic [1:0] base, input int k);
        logic [2:0] sum;
        sum = {1'b0, base} + 3'(k);
        if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
        return sum[1:0];
    endfunction

    // Descending scan so the closest master after last_q is the one left standing.
    always_comb begin
        lock_pad     = 4'(m_lock);
        elig         = 4'(m_req & (m_wr | m_rd));
        lock_release = lock_valid_q & ~lock_pad[owner_q];
        if (lock_valid_q && !lock_release) elig = elig & (4'b0001 << owner_q);
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (elig[rr_next(last_q, k)]) begin
                win_found = 1'b1;
                win_idx   = rr_next(last_q, k);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        owner_d      = owner_q;
        lock_valid_d = lock_valid_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        wr_d         = wr_q;
        rd_d         = rd_q;
        unique case (state_q)
            IDLE: begin
                if (lock_release) lock_valid_d = 1'b0;
                if (win_found) begin
                    state_d      = ACCESS;
                    grant_d      = win_idx;
                    last_d       = win_idx;
                    owner_d      = win_idx;
                    lock_valid_d = lock_pad[win_idx];
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (win_idx == 2'(i)) begin
                            addr_d  = m_addr[i*AW +: AW];
                            wdata_d = m_wdata[i*DW +: DW];
                            wr_d    = m_wr[i];
                            rd_d    = m_rd[i];
                        end
                    end
                end
            end
            ACCESS:  state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_q       <= 2'(NUM_REQ - 1);
            owner_q      <= '0;
            lock_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            lock_valid_q <= lock_valid_d;
        end
    end

    // Command and read data are only observed through state-gated outputs, so they carry no reset.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wr_q    <= wr_d;
        rd_q    <= rd_d;
        if (state_q == ACCESS) rdata_q <= pio_rd ? pio_rdata : '0;
    end

    assign busy      = (state_q != IDLE);
    assign grant_id  = grant_q;
    assign pio_wr    = (state_q == ACCESS) & wr_q;
    assign pio_rd    = (state_q == ACCESS) & rd_q & ~wr_q;
    assign pio_addr  = (state_q == ACCESS) ? addr_q : '0;
    assign pio_wdata = (state_q == ACCESS) ? wdata_q : '0;
    assign m_rdata   = (state_q == ACK) ? rdata_q : '0;

    always_comb begin
        m_ack = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            m_ack[i] = (state_q == ACK) && (grant_q == 2'(i));
        end
    end
endmodule

// File: tb/tb_atmega_pio_arb.sv
// Bench for atmega_pio_arb: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized multi-master traffic.
module tb_atmega_pio_arb;
    localparam int NR = 2;
    localparam int AW = 8;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    m_req, m_lock, m_wr, m_rd, m_ack;
    logic [NR*AW-1:0] m_addr;
    logic [NR*DW-1:0] m_wdata;
    logic [DW-1:0]    m_rdata, pio_wdata, pio_rdata;
    logic [1:0]       grant_id;
    logic             busy, pio_wr, pio_rd;
    logic [AW-1:0]    pio_addr;

    logic [DW-1:0] pmem [256];
    logic [DW-1:0] mmem [256];
    int total = 0;
    int bad   = 0;

    atmega_pio_arb #(.NUM_REQ(NR), .BUS_ADDR_DATA_LEN(AW), .PORT_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_lock(m_lock), .m_wr(m_wr), .m_rd(m_rd),
        .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata), .grant_id(grant_id), .busy(busy),
        .pio_addr(pio_addr), .pio_wr(pio_wr), .pio_rd(pio_rd),
        .pio_wdata(pio_wdata), .pio_rdata(pio_rdata)
    );

    always #5 clk = ~clk;

    // Stand-in for the atmega_pio register file: combinational read, write on the clock.
    assign pio_rdata = pmem[pio_addr];
    always @(posedge clk) if (pio_wr) pmem[pio_addr] <= pio_wdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: one transaction at a time, timed by cycle arithmetic from its grant.
    int            cyc, tg, tm, last_m, gid_m, owner_m, cand;
    bit            have, held, twr, trd, e_str, e_ack;
    logic [AW-1:0] taddr;
    logic [DW-1:0] twdata, trdata;
    logic [NR-1:0] elig;

    always @(negedge clk) begin
        if (rst) begin
            have = 0; held = 0; last_m = NR - 1; gid_m = 0; owner_m = 0; cyc = 0; tg = 0;
            check("reset_outputs", 32'({busy, pio_wr, pio_rd, pio_addr, pio_wdata, m_ack, m_rdata, grant_id}), 32'd0);
        end else begin
            cyc++;
            e_str = have && (cyc == tg + 1);
            e_ack = have && (cyc == tg + 2);
            check("busy",      32'(busy),      32'(e_str || e_ack));
            check("pio_wr",    32'(pio_wr),    32'(e_str && twr));
            check("pio_rd",    32'(pio_rd),    32'(e_str && trd && !twr));
            check("pio_addr",  32'(pio_addr),  e_str ? 32'(taddr) : 32'd0);
            check("pio_wdata", 32'(pio_wdata), e_str ? 32'(twdata) : 32'd0);
            check("m_ack",     32'(m_ack),     e_ack ? (32'd1 << tm) : 32'd0);
            check("m_rdata",   32'(m_rdata),   e_ack ? 32'(trdata) : 32'd0);
            check("grant_id",  32'(grant_id),  32'(gid_m));
            if (e_str) begin
                trdata = twr ? '0 : mmem[taddr];
                if (twr) mmem[taddr] = twdata;
            end
            if (!have || cyc > tg + 2) begin
                have = 0;
                elig = m_req & (m_wr | m_rd);
                if (held) begin
                    if (m_lock[owner_m]) elig = elig & NR'(1 << owner_m);
                    else held = 0;
                end
                for (int k = 1; k <= NR; k++) begin
                    cand = (last_m + k) % NR;
                    if (!have && elig[cand]) begin
                        have = 1; tg = cyc; tm = cand;
                        taddr = m_addr[cand*AW +: AW]; twdata = m_wdata[cand*DW +: DW];
                        twr = m_wr[cand]; trd = m_rd[cand];
                        last_m = cand; gid_m = cand; owner_m = cand; held = m_lock[cand];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs();
        m_req = '0; m_lock = '0; m_wr = '0; m_rd = '0; m_addr = '0; m_wdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int i, input int lim);
        bit got;
        got = 0;
        for (int n = 0; n < lim && !got; n++) begin
            tick();
            got = m_ack[i];
        end
        check("wait_ack", 32'(got), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    bit            seq [8];
    int            nacks;
    int            nil_cnt [NR];
    logic [DW-1:0] v;
    logic [1:0]    cmd;

    initial begin
        rst = 1'b1;
        clear_inputs();
        for (int a = 0; a < 256; a++) begin
            v = 8'($urandom);
            pmem[a] <= v;
            mmem[a] = v;
        end
        pmem[4] <= 8'hA5; mmem[4] = 8'hA5;
        pmem[9] <= 8'h3C; mmem[9] = 8'h3C;
        do_reset();

        // single read
        m_req[0] = 1; m_rd[0] = 1; m_addr[7:0] = 8'h04;
        tick();
        check("t1_pio_rd",   32'(pio_rd),   32'd1);
        check("t1_pio_wr",   32'(pio_wr),   32'd0);
        check("t1_pio_addr", 32'(pio_addr), 32'h04);
        tick();
        check("t1_ack",   32'(m_ack),   32'b01);
        check("t1_rdata", 32'(m_rdata), 32'hA5);
        clear_inputs();
        tick();
        check("t1_idle_after", 32'({m_ack, m_rdata, pio_wr}), 32'd0);

        // two continuous writers alternate
        do_reset();
        m_req = 2'b11; m_wr = 2'b11; m_addr = {8'h11, 8'h10}; m_wdata = {8'h44, 8'h33};
        nacks = 0;
        for (int n = 0; n < 14; n++) begin
            tick();
            if (m_ack != 0 && nacks < 8) begin
                seq[nacks] = m_ack[1];
                nacks++;
            end
        end
        check("t2_nacks", 32'(nacks >= 4), 32'd1);
        check("t2_seq", 32'({seq[0], seq[1], seq[2], seq[3]}), 32'b0101);
        check("t2_mem10", 32'(pmem[8'h10]), 32'h33);
        check("t2_mem11", 32'(pmem[8'h11]), 32'h44);
        clear_inputs();
        tick();

        // locked read-modify-write by m1 while m0 waits
        do_reset();
        m_req[1] = 1; m_rd[1] = 1; m_lock[1] = 1; m_addr[15:8] = 8'h00;
        wait_ack(1, 6);
        m_rd[1] = 0; m_wr[1] = 1; m_wdata[15:8] = 8'h5A;
        m_req[0] = 1; m_wr[0] = 1; m_addr[7:0] = 8'h07; m_wdata[7:0] = 8'h77;
        wait_ack(1, 6);
        check("t3_rmw_write", 32'(pmem[0]), 32'h5A);
        m_req[1] = 0; m_wr[1] = 0;
        for (int n = 0; n < 4; n++) begin
            tick();
            check("t3_stall", 32'({busy, m_ack}), 32'd0);
        end
        m_lock[1] = 0;
        tick();
        check("t3_m0_strobe", 32'({pio_wr, pio_addr}), 32'h107);
        tick();
        check("t3_m0_ack", 32'(m_ack), 32'b01);
        clear_inputs();
        tick();

        // write wins over read
        do_reset();
        m_req[0] = 1; m_wr[0] = 1; m_rd[0] = 1; m_addr[7:0] = 8'h03; m_wdata[7:0] = 8'h0F;
        tick();
        check("t4_strobes", 32'({pio_wr, pio_rd}), 32'b10);
        check("t4_wdata",   32'(pio_wdata),        32'h0F);
        tick();
        check("t4_ack",   32'(m_ack),   32'b01);
        check("t4_rdata", 32'(m_rdata), 32'h00);
        clear_inputs();
        tick();

        // reset in the middle of an access
        do_reset();
        m_req = 2'b11; m_wr = 2'b11; m_addr = {8'h0A, 8'h09}; m_wdata = {8'h11, 8'hEE};
        tick();
        check("t5_in_access", 32'({pio_wr, pio_addr}), 32'h109);
        rst = 1'b1;
        #1;
        check("t5_async_drop", 32'({pio_wr, pio_rd, m_ack, busy}), 32'd0);
        tick();
        check("t5_discarded", 32'(pmem[9]), 32'h3C);
        rst = 1'b0;
        tick();
        tick();
        check("t5_first_grant", 32'(m_ack), 32'b01);
        clear_inputs();
        tick();

        // request without a command is ignored
        do_reset();
        m_req[0] = 1;
        for (int n = 0; n < 10; n++) begin
            tick();
            check("t6_ignored", 32'({busy, m_ack, pio_wr, pio_rd}), 32'd0);
        end
        clear_inputs();
        tick();

        // randomized traffic
        for (int i = 0; i < NR; i++) nil_cnt[i] = 0;
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            for (int i = 0; i < NR; i++) begin
                if (m_req[i]) begin
                    if (m_ack[i]) begin
                        m_req[i] = 0; m_wr[i] = 0; m_rd[i] = 0;
                    end else if (!(m_wr[i] || m_rd[i])) begin
                        nil_cnt[i]--;
                        if (nil_cnt[i] <= 0) m_req[i] = 0;
                    end else if ($urandom_range(7) == 0) begin
                        m_wdata[i*DW +: DW] = 8'($urandom);
                    end
                end else begin
                    if (m_lock[i] && $urandom_range(1) == 1) m_lock[i] = 0;
                    if ($urandom_range(2) == 0) begin
                        cmd = 2'($urandom);
                        m_req[i] = 1; m_wr[i] = cmd[0]; m_rd[i] = cmd[1];
                        m_addr[i*AW +: AW]  = 8'($urandom_range(15));
                        m_wdata[i*DW +: DW] = 8'($urandom);
                        m_lock[i] = ($urandom_range(3) == 0);
                        nil_cnt[i] = 1 + $urandom_range(3);
                    end
                end
            end
            tick();
        end
        clear_inputs();
        tick();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
